// File: rtl/eth_phy_10g_pkg.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_pkg
// Shared constants for the 10G PHY SERDES receive model.
//   BLOCK_W    : width of one 64b/66b block (payload + sync header)
//   SYNC_DATA  : sync header of a data block
//   SYNC_CTRL  : sync header of a control block
//   OFFSET_W   : width of the bit-offset register
//   MAX_OFFSET : largest legal bit offset; the next slip wraps to 0
// ---------------------------------------------------------------------------
package eth_phy_10g_pkg;

  localparam int          BLOCK_W    = 66;
  localparam logic [1:0]  SYNC_DATA  = 2'b10;
  localparam logic [1:0]  SYNC_CTRL  = 2'b01;
  localparam int          OFFSET_W   = 7;
  localparam int          MAX_OFFSET = 65;

  // One block as it sits in the shift buffer: bit 0 is the first serial bit.
  typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/eth_phy_10g_serdes_rx_model_if.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_serdes_rx_model_if
// Block stream between the TX side and the windowed RX side.
//   in_data/in_hdr/in_valid    : block presented by the TX side
//   out_data/out_hdr/out_valid : windowed block returned to the RX side
// Modports:
//   master : drives in_*, observes out_*
//   slave  : the model; consumes in_*, drives out_*
// ---------------------------------------------------------------------------
interface eth_phy_10g_serdes_rx_model_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);

  logic [DATA_WIDTH-1:0] in_data;
  logic [HDR_WIDTH-1:0]  in_hdr;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [HDR_WIDTH-1:0]  out_hdr;
  logic                  out_valid;

  modport master (
    output in_data, in_hdr, in_valid,
    input  out_data, out_hdr, out_valid
  );

  modport slave (
    input  in_data, in_hdr, in_valid,
    output out_data, out_hdr, out_valid
  );

endinterface

// File: rtl/eth_phy_10g_slip_ctrl.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_slip_ctrl
// Turns the frame-sync bitslip level into single-bit offset steps.
// A rising edge of i_bitslip is one request; it is applied only when the
// holdoff counter is zero, otherwise it is dropped (never queued).
// Ports:
//   i_clk         : clock
//   i_rst_n       : synchronous active-low reset
//   i_bitslip     : bitslip level from frame sync
//   o_slip_offset : current bit offset, 0..MAX_OFFSET, wraps to 0
//   o_slip_count  : number of applied slips, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module eth_phy_10g_slip_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int INIT_OFFSET  = 0,
  parameter int SLIP_HOLDOFF = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_bitslip,
  output logic [OFFSET_W-1:0] o_slip_offset,
  output logic [15:0]         o_slip_count
);

  localparam int HOLD_W = $clog2(SLIP_HOLDOFF + 1);

  logic                r_bitslip_prev;
  logic [HOLD_W-1:0]   r_holdoff;
  logic [OFFSET_W-1:0] r_offset;
  logic [15:0]         r_count;

  logic w_req;
  logic w_apply;

  assign w_req   = i_bitslip & ~r_bitslip_prev;
  assign w_apply = w_req && (r_holdoff == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bitslip_prev <= 1'b0;
      r_holdoff      <= '0;
      r_offset       <= OFFSET_W'(INIT_OFFSET);
      r_count        <= '0;
    end else begin
      r_bitslip_prev <= i_bitslip;
      if (w_apply) begin
        r_offset  <= (r_offset == OFFSET_W'(MAX_OFFSET)) ? '0 : r_offset + 1'b1;
        r_count   <= (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
        r_holdoff <= HOLD_W'(SLIP_HOLDOFF);
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - 1'b1;
      end
    end
  end

  assign o_slip_offset = r_offset;
  assign o_slip_count  = r_count;

endmodule

// File: rtl/eth_phy_10g_serdes_rx_model.sv
// ---------------------------------------------------------------------------
// eth_phy_10g_serdes_rx_model
// SERDES receive-side model that answers the frame-sync bitslip request.
// Incoming 66-bit blocks are shifted into a two-block buffer {cur, prev};
// a 66-bit window is taken at the current bit offset and registered out.
// At offset 0 the output is the block accepted two in_valid edges earlier.
// Ports:
//   rx_clk      : clock
//   rx_rst_n    : synchronous active-low reset
//   bus         : slave side of the block stream (in_* in, out_* out)
//   bitslip     : bitslip level; each rising edge requests a one-bit slip
//   slip_offset : current bit offset, 0..65
//   slip_count  : applied slips, saturating
//   inj_hdr_err : (ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN only) rising edge
//                 forces the next output header to 2'b00
//   inj_count   : (ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN only) forced headers,
//                 saturating
// Optional feature macro: ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
// ---------------------------------------------------------------------------
module eth_phy_10g_serdes_rx_model
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int HDR_WIDTH    = 2,
  parameter int INIT_OFFSET  = 0,
  parameter int SLIP_HOLDOFF = 8
) (
  input  logic                          rx_clk,
  input  logic                          rx_rst_n,
  eth_phy_10g_serdes_rx_model_if.slave  bus,
  input  logic                          bitslip,
  output logic [OFFSET_W-1:0]           slip_offset,
  output logic [15:0]                   slip_count
`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
  ,
  input  logic                          inj_hdr_err,
  output logic [15:0]                   inj_count
`endif
);

  localparam int BW = DATA_WIDTH + HDR_WIDTH;

  logic [2*BW-1:0]       r_buf;      // {cur, prev}; prev holds the earlier serial bits
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [HDR_WIDTH-1:0]  r_out_hdr;
  logic                  r_out_valid;

  logic [OFFSET_W-1:0]   w_slip_offset;
  logic [BW-1:0]         w_window;
  logic [HDR_WIDTH-1:0]  w_hdr_eff;

  eth_phy_10g_slip_ctrl #(
    .INIT_OFFSET  (INIT_OFFSET),
    .SLIP_HOLDOFF (SLIP_HOLDOFF)
  ) u_slip_ctrl (
    .i_clk         (rx_clk),
    .i_rst_n       (rx_rst_n),
    .i_bitslip     (bitslip),
    .o_slip_offset (w_slip_offset),
    .o_slip_count  (slip_count)
  );

  // Window is taken from the buffer before this edge's update, with the
  // offset before this edge's slip: a slip on the same edge affects the
  // following block only.
  assign w_window = r_buf[w_slip_offset +: BW];

`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
  logic        r_inj_prev;
  logic        r_inj_pend;
  logic [15:0] r_inj_count;
  logic        w_inj_req;

  assign w_inj_req = inj_hdr_err & ~r_inj_prev;
  assign w_hdr_eff = r_inj_pend ? '0 : w_window[HDR_WIDTH-1:0];

  // A pending request is consumed by the next accepted block; further edges
  // seen while pending simply merge into it.
  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_inj_prev  <= 1'b0;
      r_inj_pend  <= 1'b0;
      r_inj_count <= '0;
    end else begin
      r_inj_prev <= inj_hdr_err;
      if (bus.in_valid && r_inj_pend) begin
        r_inj_pend  <= w_inj_req;
        r_inj_count <= (r_inj_count == 16'hFFFF) ? r_inj_count : r_inj_count + 16'd1;
      end else if (w_inj_req) begin
        r_inj_pend <= 1'b1;
      end
    end
  end

  assign inj_count = r_inj_count;
`else
  assign w_hdr_eff = w_window[HDR_WIDTH-1:0];
`endif

  always_ff @(posedge rx_clk) begin
    if (!rx_rst_n) begin
      r_buf       <= '0;
      r_out_data  <= '0;
      r_out_hdr   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_buf      <= {bus.in_data, bus.in_hdr, r_buf[2*BW-1:BW]};
        r_out_data <= w_window[BW-1:HDR_WIDTH];
        r_out_hdr  <= w_hdr_eff;
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_hdr   = r_out_hdr;
  assign bus.out_valid = r_out_valid;

  assign slip_offset = w_slip_offset;

endmodule

// File: tb/tb_eth_phy_10g_serdes_rx_model.sv
// ---------------------------------------------------------------------------
// tb_eth_phy_10g_serdes_rx_model
// Directed bench for the SERDES RX model: reset, offset-0 passthrough,
// single slip, slip during a block, offset wrap, holdoff and (with
// ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN) header error injection.
// ---------------------------------------------------------------------------
module tb_eth_phy_10g_serdes_rx_model;
  import eth_phy_10g_pkg::*;

  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] PAT_A = 64'h0707070707070707;
  localparam logic [63:0] PAT_B = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] PAT_C = 64'h0000_0000_0000_001E;
  localparam logic [63:0] PAT_D = 64'h1234_5678_9ABC_DEF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bitslip = 1'b0;
  logic [6:0]  slip_offset;
  logic [15:0] slip_count;
`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
  logic        inj_hdr_err = 1'b0;
  logic [15:0] inj_count;
`endif

  int n_run  = 0;
  int n_fail = 0;

  eth_phy_10g_serdes_rx_model_if u_if ();

  eth_phy_10g_serdes_rx_model #(
    .DATA_WIDTH   (64),
    .HDR_WIDTH    (2),
    .INIT_OFFSET  (0),
    .SLIP_HOLDOFF (8)
  ) dut (
    .rx_clk      (clk),
    .rx_rst_n    (rst_n),
    .bus         (u_if),
    .bitslip     (bitslip),
    .slip_offset (slip_offset),
    .slip_count  (slip_count)
`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
    ,
    .inj_hdr_err (inj_hdr_err),
    .inj_count   (inj_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, let one rising edge pass, return at the
  // falling edge where outputs are stable for checking.
  task automatic cyc(input logic v, input logic [1:0] h, input logic [63:0] d,
                     input logic bs);
    u_if.in_valid = v;
    u_if.in_hdr   = h;
    u_if.in_data  = d;
    bitslip       = bs;
    @(negedge clk);
    if (v)
      $display("[TB] blk in hdr=%b data=%h -> out hdr=%b data=%h valid=%b off=%0d",
               h, d, u_if.out_hdr, u_if.out_data, u_if.out_valid, slip_offset);
  endtask

  task automatic test_reset();
    // Valid blocks and a bitslip level during reset must leave no trace.
    rst_n = 1'b0;
    cyc(1'b1, SYNC_DATA, PAT_D, 1'b1);
    cyc(1'b1, SYNC_DATA, PAT_D, 1'b1);
    n_run++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", u_if.out_valid); end
    n_run++; if (u_if.out_data !== 64'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", u_if.out_data); end
    n_run++; if (u_if.out_hdr !== 2'b00) begin n_fail++; $display("FAIL rst_hdr: got %b want 00", u_if.out_hdr); end
    n_run++; if (slip_offset !== 7'd0) begin n_fail++; $display("FAIL rst_offset: got %0d want 0", slip_offset); end
    n_run++; if (slip_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", slip_count); end
`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
    n_run++; if (inj_count !== 16'd0) begin n_fail++; $display("FAIL rst_inj_count: got %0d want 0", inj_count); end
`endif
    bitslip = 1'b0;
    u_if.in_valid = 1'b0;
    rst_n = 1'b1;
    cyc(1'b0, 2'b00, 64'h0, 1'b0);
  endtask

  task automatic test_passthrough();
    // First two outputs come from the zero-filled buffer.
    cyc(1'b1, SYNC_DATA, PAT_A, 1'b0);
    n_run++; if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid1: got %b want 1", u_if.out_valid); end
    n_run++; if (u_if.out_data !== 64'h0 || u_if.out_hdr !== 2'b00) begin n_fail++; $display("FAIL pt_zero1: got %b/%h want 00/0", u_if.out_hdr, u_if.out_data); end
    cyc(1'b1, SYNC_DATA, PAT_B, 1'b0);
    n_run++; if (u_if.out_data !== 64'h0 || u_if.out_hdr !== 2'b00) begin n_fail++; $display("FAIL pt_zero2: got %b/%h want 00/0", u_if.out_hdr, u_if.out_data); end
    cyc(1'b1, SYNC_CTRL, PAT_C, 1'b0);
    n_run++; if (u_if.out_hdr !== SYNC_DATA || u_if.out_data !== PAT_A) begin n_fail++; $display("FAIL pt_blkA: got %b/%h want 10/%h", u_if.out_hdr, u_if.out_data, PAT_A); end
    cyc(1'b1, SYNC_DATA, PAT_D, 1'b0);
    n_run++; if (u_if.out_hdr !== SYNC_DATA || u_if.out_data !== PAT_B) begin n_fail++; $display("FAIL pt_blkB: got %b/%h want 10/%h", u_if.out_hdr, u_if.out_data, PAT_B); end
    // Idle: outputs hold, valid drops.
    cyc(1'b0, 2'b11, ONES, 1'b0);
    n_run++; if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL pt_idle_valid: got %b want 0", u_if.out_valid); end
    n_run++; if (u_if.out_hdr !== SYNC_DATA || u_if.out_data !== PAT_B) begin n_fail++; $display("FAIL pt_idle_hold: got %b/%h want 10/%h", u_if.out_hdr, u_if.out_data, PAT_B); end
    // After the gap the stream resumes with the control block.
    cyc(1'b1, SYNC_DATA, PAT_A, 1'b0);
    n_run++; if (u_if.out_hdr !== SYNC_CTRL || u_if.out_data !== PAT_C || u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL pt_blkC: got %b/%h/%b want 01/%h/1", u_if.out_hdr, u_if.out_data, u_if.out_valid, PAT_C); end
    cyc(1'b0, 2'b00, 64'h0, 1'b0);
  endtask

  task automatic test_single_slip();
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    cyc(1'b0, 2'b00, 64'h0, 1'b1);
    cyc(1'b0, 2'b00, 64'h0, 1'b0);
    n_run++; if (slip_offset !== 7'd1) begin n_fail++; $display("FAIL ss_offset: got %0d want 1", slip_offset); end
    n_run++; if (slip_count !== 16'd1) begin n_fail++; $display("FAIL ss_count: got %0d want 1", slip_count); end
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    n_run++; if (u_if.out_hdr !== 2'b11 || u_if.out_data !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ss_window1: got %b/%h want 11/7fffffffffffffff", u_if.out_hdr, u_if.out_data); end
    repeat (10) cyc(1'b0, 2'b00, 64'h0, 1'b0);
    // Slip and block on the same edge: this output still uses offset 1.
    cyc(1'b1, SYNC_DATA, ONES, 1'b1);
    n_run++; if (u_if.out_hdr !== 2'b11 || u_if.out_data !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ss_same_edge: got %b/%h want 11/7fffffffffffffff", u_if.out_hdr, u_if.out_data); end
    n_run++; if (slip_offset !== 7'd2 || slip_count !== 16'd2) begin n_fail++; $display("FAIL ss_offset2: got %0d/%0d want 2/2", slip_offset, slip_count); end
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    n_run++; if (u_if.out_hdr !== 2'b11 || u_if.out_data !== 64'hBFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ss_window2: got %b/%h want 11/bfffffffffffffff", u_if.out_hdr, u_if.out_data); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 66; i++) begin
      cyc(1'b0, 2'b00, 64'h0, 1'b1);
      repeat (9) cyc(1'b0, 2'b00, 64'h0, 1'b0);
      if (i == 64) begin
        n_run++; if (slip_offset !== 7'd65) begin n_fail++; $display("FAIL wr_offset65: got %0d want 65", slip_offset); end
      end
    end
    n_run++; if (slip_offset !== 7'd0) begin n_fail++; $display("FAIL wr_offset0: got %0d want 0", slip_offset); end
    n_run++; if (slip_count !== 16'd66) begin n_fail++; $display("FAIL wr_count: got %0d want 66", slip_count); end
    cyc(1'b1, SYNC_DATA, PAT_A, 1'b0);
    cyc(1'b1, SYNC_DATA, PAT_B, 1'b0);
    cyc(1'b1, SYNC_DATA, PAT_C, 1'b0);
    n_run++; if (u_if.out_hdr !== SYNC_DATA || u_if.out_data !== PAT_A) begin n_fail++; $display("FAIL wr_blkA: got %b/%h want 10/%h", u_if.out_hdr, u_if.out_data, PAT_A); end
    cyc(1'b1, SYNC_DATA, PAT_D, 1'b0);
    n_run++; if (u_if.out_hdr !== SYNC_DATA || u_if.out_data !== PAT_B) begin n_fail++; $display("FAIL wr_blkB: got %b/%h want 10/%h", u_if.out_hdr, u_if.out_data, PAT_B); end
  endtask

  task automatic test_holdoff();
    // Rising edges at cycles 0, 4, 8, 12; only 0 and 12 fall outside holdoff.
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 2'b00, 64'h0, ((i / 2) % 2) == 0);
    cyc(1'b0, 2'b00, 64'h0, 1'b0);
    n_run++; if (slip_count !== 16'd2) begin n_fail++; $display("FAIL ho_count: got %0d want 2", slip_count); end
    n_run++; if (slip_offset !== 7'd2) begin n_fail++; $display("FAIL ho_offset: got %0d want 2", slip_offset); end
  endtask

`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
  task automatic test_err_inj();
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    // Two request edges before the next block merge into one.
    inj_hdr_err = 1'b1; cyc(1'b0, 2'b00, 64'h0, 1'b0);
    inj_hdr_err = 1'b0; cyc(1'b0, 2'b00, 64'h0, 1'b0);
    inj_hdr_err = 1'b1; cyc(1'b0, 2'b00, 64'h0, 1'b0);
    inj_hdr_err = 1'b0; cyc(1'b0, 2'b00, 64'h0, 1'b0);
    n_run++; if (inj_count !== 16'd0) begin n_fail++; $display("FAIL ei_count_pre: got %0d want 0", inj_count); end
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    n_run++; if (u_if.out_hdr !== 2'b00 || u_if.out_data !== ONES) begin n_fail++; $display("FAIL ei_forced: got %b/%h want 00/%h", u_if.out_hdr, u_if.out_data, ONES); end
    n_run++; if (inj_count !== 16'd1) begin n_fail++; $display("FAIL ei_count1: got %0d want 1", inj_count); end
    cyc(1'b1, SYNC_DATA, ONES, 1'b0);
    n_run++; if (u_if.out_hdr !== SYNC_DATA) begin n_fail++; $display("FAIL ei_clean: got %b want 10", u_if.out_hdr); end
    n_run++; if (inj_count !== 16'd1) begin n_fail++; $display("FAIL ei_count_post: got %0d want 1", inj_count); end
  endtask
`endif

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_hdr   = 2'b00;
    u_if.in_data  = 64'h0;
    test_reset();
    test_passthrough();
    test_reset();
    test_single_slip();
    test_reset();
    test_wrap();
    test_reset();
    test_holdoff();
    test_reset();
`ifdef ETH_PHY_10G_SERDES_MODEL_ERR_INJ_EN
    test_err_inj();
    test_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
